ps2_keypad: RTL
===============

PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 Parameter N_KEYS, default 4, number of tracked keys (2..8).
REQ-002 Parameter KEY_CODES, default {9'h174,9'h16b,9'h172,9'h175}, packed N_KEYS x 9-bit scan codes, index 0 in LSBs (0 up, 1 down, 2 left, 3 right); bit 8 = E0-extended flag.
REQ-003 Parameter DEB_N, default 2, stable cycles required before a key state change is accepted (1..255).
REQ-004 Parameter REPEAT_CYC, default 0, auto-repeat period in clk cycles; 0 disables repeat.
REQ-005 Parameter DIR_RST, default N_KEYS-1, dir value after reset.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 code  input  9  scan code from PS/2 receiver, bit 8 = E0 prefix seen.
REQ-009 code_vld  input  1  one-cycle strobe, code/code_brk valid.
REQ-010 code_brk  input  1  F0 (release) prefix preceded this code.
REQ-011 key_down  output  N_KEYS  debounced held state per key.
REQ-012 key_press  output  N_KEYS  one-cycle pulse on key_down rise.
REQ-013 key_rel  output  N_KEYS  one-cycle pulse on key_down fall.
REQ-014 dir  output  DW  index of most recently pressed key; DW = max(1, clog2(N_KEYS)).
REQ-015 dir_vld  output  1  one-cycle pulse on dir update or auto-repeat.

Function
REQ-016 code_vld with code == KEY_CODES[i] SHALL set raw[i] = !code_brk on the next clk edge; unmatched codes SHALL be ignored.
REQ-017 Per key: a counter SHALL count consecutive cycles with raw[i] != key_down[i]; at DEB_N, key_down[i] toggles and the counter clears; any cycle with raw[i] == key_down[i] clears the counter.
REQ-018 Latency: an uncontested make/break SHALL change key_down exactly DEB_N+1 cycles after the code_vld cycle; a contrary event inside the window cancels the change.
REQ-019 key_press/key_rel SHALL assert in the same cycle key_down changes, for exactly one cycle.
REQ-020 Any key_press SHALL load dir with that index and pulse dir_vld in the same cycle; simultaneous presses: lowest index wins.
REQ-021 Release of the dir key SHALL NOT change dir nor pulse dir_vld; dir holds last value.
REQ-022 Repeated make codes (typematic) for an already-down key SHALL produce no key_press and no dir_vld.
REQ-023 REPEAT_CYC > 0: repeat counter clears on every dir update; while key_down[dir] = 1 it counts, pulsing dir_vld and restarting every REPEAT_CYC cycles; counting stops and clears when key_down[dir] = 0.
REQ-024 Repeat pulse coinciding with a dir update SHALL yield one dir_vld pulse, not two.
REQ-025 Counters SHALL saturate, never wrap.

Reset
REQ-026 rst low SHALL asynchronously clear raw, key_down, key_press, key_rel, dir_vld, all counters, and set dir = DIR_RST.
REQ-027 Reset mid-debounce or mid-repeat SHALL discard the pending event; after release, no key is down until new make codes arrive.

Structure
REQ-028 Shared package ps2_pkg SHALL hold default scan-code constants (UP 9'h175, DOWN 9'h172, LEFT 9'h16b, RIGHT 9'h174), direction encodings and DW function.
REQ-029 One sub-module ps2_key_deb (raw latch + debounce counter + edge pulses) SHALL be instantiated N_KEYS times via generate; priority select and repeat logic stay in ps2_keypad.

Verification
REQ-030 Defaults; code_vld code=9'h175 brk=0 at cycle t -> key_down[0]=1, key_press[0] pulse, dir=0, dir_vld pulse at t+3.
REQ-031 Make 9'h172 then break 9'h172 one cycle later -> no key_down, key_press, or dir_vld change.
REQ-032 Makes 9'h16b and 9'h174 same-window (cycles t, t) via back-to-back strobes t, t+1 -> dir=2 at t+3, then dir=3 with second dir_vld at t+4; break 9'h174 -> key_rel[3] pulse, dir stays 3.
REQ-033 REPEAT_CYC=10; hold 9'h175 -> dir_vld at press then every 10 cycles; break -> pulses stop after key_down falls.
REQ-034 Press 9'h174, assert rst mid-debounce (cycle t+1) -> dir=3 (DIR_RST), key_down=0, no pulses after release.
REQ-035 Unmatched code 9'h01c and repeated make of held key -> outputs unchanged, no pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: constants shared by the PS/2 keypad block.
//   - Default 9-bit scan codes for the four arrow keys. Bit 8 flags an
//     E0-extended code.
//   - Direction indices, matching the default KEY_CODES ordering.
//   - dw_f(): width of the dir output for a given key count.
package ps2_pkg;

  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16b;
  localparam logic [8:0] KEY_RIGHT = 9'h174;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // The dir output is at least one bit wide.
  function automatic int dw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_key_deb.sv
// ps2_key_deb: tracks one key and debounces its held state.
// It latches make/break codes that match KEY_CODE into a raw state. The held
// state follows the raw state only after DEB_N consecutive disagreeing cycles.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   code, code_vld   scan code and its one-cycle strobe
//   code_brk         release prefix flag for the current code
//   key_down         debounced held state (registered)
//   key_press        one-cycle pulse, registered with key_down rise
//   key_rel          one-cycle pulse, registered with key_down fall
//   press_nxt        combinational: a rise will be registered on this edge
module ps2_key_deb #(
  parameter logic [8:0] KEY_CODE = 9'h175,
  parameter int         DEB_N    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] code,
  input  logic       code_vld,
  input  logic       code_brk,
  output logic       key_down,
  output logic       key_press,
  output logic       key_rel,
  output logic       press_nxt
);

  logic       raw_q, raw_d;
  logic       down_q, down_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    raw_d = raw_q;
    if (code_vld && (code == KEY_CODE)) raw_d = ~code_brk;

    // The count reaches DEB_N-1 after the raw state has disagreed for DEB_N
    // cycles. The toggle is then registered on the DEB_N-th disagreeing edge.
    // That edge is DEB_N+1 edges after the strobe cycle.
    down_d = down_q;
    cnt_d  = '0;
    if (raw_q != down_q) begin
      if (cnt_q >= 8'(DEB_N - 1)) begin
        down_d = ~down_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    press_d = down_d & ~down_q;
    rel_d   = ~down_d & down_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q   <= 1'b0;
      down_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      raw_q   <= raw_d;
      down_q  <= down_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_down  = down_q;
  assign key_press = press_q;
  assign key_rel   = rel_q;
  assign press_nxt = press_d;

endmodule

// File: rtl/ps2_keypad.sv
// ps2_keypad: debounced multi-key tracker driven by decoded PS/2 scan codes.
// Each key tracks its own held state. dir holds the index of the most
// recently pressed key. dir_vld pulses on each new press. When REPEAT_CYC is
// non-zero, dir_vld also pulses every REPEAT_CYC cycles while the dir key is
// held.
// Ports:
//   clk, rst    clock; asynchronous active-low reset
//   code        9-bit scan code (bit 8 = E0 prefix)
//   code_vld    one-cycle strobe qualifying code/code_brk
//   code_brk    release (F0) prefix flag
//   key_down    debounced held state per key
//   key_press   one-cycle pulse per key on press
//   key_rel     one-cycle pulse per key on release
//   dir         index of the most recently pressed key
//   dir_vld     one-cycle pulse on a dir update or an auto-repeat
// Inputs follow strobe semantics. There is no back-pressure: the block
// consumes a code on every cycle in which code_vld is high.
module ps2_keypad import ps2_pkg::*; #(
  parameter int                  N_KEYS     = 4,
  parameter logic [N_KEYS*9-1:0] KEY_CODES  = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP},
  parameter int                  DEB_N      = 2,
  parameter int                  REPEAT_CYC = 0,
  parameter int                  DIR_RST    = N_KEYS - 1,
  localparam int                 DW         = dw_f(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        code,
  input  logic              code_vld,
  input  logic              code_brk,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_rel,
  output logic [DW-1:0]     dir,
  output logic              dir_vld
);

  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC + 1) : 1;

  logic [N_KEYS-1:0] press_nxt;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    ps2_key_deb #(
      .KEY_CODE (KEY_CODES[i*9 +: 9]),
      .DEB_N    (DEB_N)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .code      (code),
      .code_vld  (code_vld),
      .code_brk  (code_brk),
      .key_down  (key_down[i]),
      .key_press (key_press[i]),
      .key_rel   (key_rel[i]),
      .press_nxt (press_nxt[i])
    );
  end

  logic [DW-1:0] dir_q, dir_d;
  logic          dir_vld_q, dir_vld_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          upd;
  logic          held;
  logic          rep_pulse;

  always_comb begin
    // The loop runs from high index to low, so the lowest-index press wins.
    upd   = 1'b0;
    dir_d = dir_q;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_nxt[i]) begin
        upd   = 1'b1;
        dir_d = DW'(i);
      end
    end

    held = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (dir_q == DW'(i)) held = key_down[i];
    end

    // A dir update restarts the repeat period. The update then supplies the
    // only dir_vld pulse for that cycle. The count never exceeds
    // REPEAT_CYC-1, so it cannot wrap.
    rep_d     = '0;
    rep_pulse = 1'b0;
    if ((REPEAT_CYC != 0) && !upd && held) begin
      if (rep_q >= RW'(REPEAT_CYC - 1)) begin
        rep_pulse = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end

    dir_vld_d = upd | rep_pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q     <= DW'(DIR_RST);
      dir_vld_q <= 1'b0;
      rep_q     <= '0;
    end else begin
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
      rep_q     <= rep_d;
    end
  end

  assign dir     = dir_q;
  assign dir_vld = dir_vld_q;

endmodule
